// File: rtl/fifo_pkg.sv
// Shared constants and helper functions for the parametrised FIFO family.
package fifo_pkg;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_DEPTH = 8;

    // Ceiling log2; clog2(1) is 0. Usable in parameter expressions.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((32'sd1 <<< result) < value) begin
            result = result + 1;
        end
        return result;
    endfunction

    // Advance a pointer by one and wrap at depth-1 explicitly. Depth need
    // not be a power of two, so plain binary overflow is not enough.
    function automatic int unsigned ptr_inc(input int unsigned ptr,
                                            input int unsigned depth);
        if (ptr >= (depth - 32'd1)) begin
            return 32'd0;
        end else begin
            return ptr + 32'd1;
        end
    endfunction

endpackage

// File: rtl/fifo_param_if.sv
// Producer/consumer-facing bus of the parametrised FIFO.
interface fifo_param_if
    import fifo_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH
);
    localparam int CW = clog2(DEPTH + 1);

    logic             wn;
    logic             rn;
    logic [WIDTH-1:0] DATAIN;
    logic [WIDTH-1:0] DATAOUT;
    logic             full;
    logic             empty;
    logic             almost_full;
    logic             almost_empty;
    logic [CW-1:0]    count;
    logic             overflow;
    logic             underflow;

    // Side that issues writes and reads.
    modport master (
        output wn, rn, DATAIN,
        input  DATAOUT, full, empty, almost_full, almost_empty,
               count, overflow, underflow
    );

    // The FIFO itself.
    modport slave (
        input  wn, rn, DATAIN,
        output DATAOUT, full, empty, almost_full, almost_empty,
               count, overflow, underflow
    );

endinterface

// File: rtl/fifo_mem.sv
// Simple dual-port register array: synchronous write, synchronous read
// whose output register holds its value when no read is requested.
module fifo_mem
    import fifo_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH,
    parameter int AW    = clog2(DEPTH)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             re,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] rdata_q;

    // Storage array; contents intentionally survive reset.
    always_ff @(posedge clock) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    // Read register: cleared by reset, loads on read, otherwise holds.
    // A same-edge write to raddr is not visible here (old data is read),
    // which is exactly what a simultaneous read/write on a full FIFO needs.
    always_ff @(posedge clock) begin
        if (reset) begin
            rdata_q <= {WIDTH{1'b0}};
        end else if (re) begin
            rdata_q <= mem_q[raddr];
        end else begin
            rdata_q <= rdata_q;
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/fifo_param.sv
// Parametrised single-clock FIFO: pointers, occupancy count, threshold
// flags and sticky error flags around a fifo_mem register array.
module fifo_param
    import fifo_pkg::*;
#(
    parameter int WIDTH     = DEF_WIDTH,
    parameter int DEPTH     = DEF_DEPTH,
    parameter int AF_MARGIN = 1,
    parameter int AE_MARGIN = 1
) (
    input  logic         clock,
    input  logic         reset,
    fifo_param_if.slave  bus
);

    localparam int AW = clog2(DEPTH);
    localparam int CW = clog2(DEPTH + 1);

    localparam logic [CW-1:0] FULL_LEVEL = CW'(DEPTH);
    localparam logic [CW-1:0] AF_LEVEL   = CW'(DEPTH - AF_MARGIN);
    localparam logic [CW-1:0] AE_LEVEL   = CW'(AE_MARGIN);

    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             overflow_q, overflow_d;
    logic             underflow_q, underflow_d;

    logic             full_s;
    logic             empty_s;
    logic             wr_ok_s;
    logic             rd_ok_s;
    logic [WIDTH-1:0] rdata_s;

    // Status flags are decoded straight from the registered count.
    assign full_s  = (count_q == FULL_LEVEL);
    assign empty_s = (count_q == {CW{1'b0}});

    // A write on a full FIFO still goes through when a read frees a slot
    // on the same edge; a read on an empty FIFO is never bypassed.
    assign wr_ok_s = bus.wn && (!full_s || bus.rn);
    assign rd_ok_s = bus.rn && !empty_s;

    // Next-state for pointers, count and sticky error flags.
    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;

        if (wr_ok_s) begin
            wr_ptr_d = AW'(ptr_inc(32'(wr_ptr_q), DEPTH));
        end else begin
            wr_ptr_d = wr_ptr_q;
        end

        if (rd_ok_s) begin
            rd_ptr_d = AW'(ptr_inc(32'(rd_ptr_q), DEPTH));
        end else begin
            rd_ptr_d = rd_ptr_q;
        end

        case ({wr_ok_s, rd_ok_s})
            2'b10:   count_d = count_q + {{(CW-1){1'b0}}, 1'b1};
            2'b01:   count_d = count_q - {{(CW-1){1'b0}}, 1'b1};
            default: count_d = count_q;
        endcase

        if (bus.wn && !wr_ok_s) begin
            overflow_d = 1'b1;
        end else begin
            overflow_d = overflow_q;
        end

        if (bus.rn && empty_s) begin
            underflow_d = 1'b1;
        end else begin
            underflow_d = underflow_q;
        end
    end

    // State registers with synchronous reset; reset discards queued data.
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_q    <= {AW{1'b0}};
            rd_ptr_q    <= {AW{1'b0}};
            count_q     <= {CW{1'b0}};
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    fifo_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clock (clock),
        .reset (reset),
        .we    (wr_ok_s),
        .waddr (wr_ptr_q),
        .wdata (bus.DATAIN),
        .re    (rd_ok_s),
        .raddr (rd_ptr_q),
        .rdata (rdata_s)
    );

    assign bus.DATAOUT      = rdata_s;
    assign bus.full         = full_s;
    assign bus.empty        = empty_s;
    assign bus.almost_full  = (count_q >= AF_LEVEL);
    assign bus.almost_empty = (count_q <= AE_LEVEL);
    assign bus.count        = count_q;
    assign bus.overflow     = overflow_q;
    assign bus.underflow    = underflow_q;

endmodule

// File: tb/tb_fifo_param.sv
// Directed self-checking bench for fifo_param (DEPTH=8 and DEPTH=5 instances).
module tb_fifo_param;

    logic clock;
    logic reset8;
    logic reset5;
    int   checks;
    int   errors;

    fifo_param_if #(.WIDTH(8), .DEPTH(8)) bus8 ();
    fifo_param_if #(.WIDTH(8), .DEPTH(5)) bus5 ();

    fifo_param #(.WIDTH(8), .DEPTH(8), .AF_MARGIN(1), .AE_MARGIN(1)) dut8 (
        .clock (clock),
        .reset (reset8),
        .bus   (bus8)
    );

    fifo_param #(.WIDTH(8), .DEPTH(5), .AF_MARGIN(1), .AE_MARGIN(1)) dut5 (
        .clock (clock),
        .reset (reset5),
        .bus   (bus5)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // One clock of stimulus on the DEPTH=8 instance; outputs are stable on return.
    task automatic cyc8(input logic w, input logic r, input logic [7:0] d);
        bus8.wn = w; bus8.rn = r; bus8.DATAIN = d;
        @(posedge clock); #1;
        bus8.wn = 1'b0; bus8.rn = 1'b0;
    endtask

    task automatic cyc5(input logic w, input logic r, input logic [7:0] d);
        bus5.wn = w; bus5.rn = r; bus5.DATAIN = d;
        @(posedge clock); #1;
        bus5.wn = 1'b0; bus5.rn = 1'b0;
    endtask

    task automatic rst8();
        reset8 = 1'b1;
        cyc8(1'b0, 1'b0, 8'd0);
        reset8 = 1'b0;
    endtask

    task automatic test_reset();
        rst8();
        checks++; if (bus8.count !== 4'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", bus8.count); end
        checks++; if (bus8.empty !== 1'b1) begin errors++; $display("FAIL reset_empty got %b exp 1", bus8.empty); end
        checks++; if (bus8.full !== 1'b0) begin errors++; $display("FAIL reset_full got %b exp 0", bus8.full); end
        checks++; if (bus8.almost_empty !== 1'b1) begin errors++; $display("FAIL reset_ae got %b exp 1", bus8.almost_empty); end
        checks++; if (bus8.almost_full !== 1'b0) begin errors++; $display("FAIL reset_af got %b exp 0", bus8.almost_full); end
        checks++; if (bus8.overflow !== 1'b0) begin errors++; $display("FAIL reset_ovf got %b exp 0", bus8.overflow); end
        checks++; if (bus8.underflow !== 1'b0) begin errors++; $display("FAIL reset_udf got %b exp 0", bus8.underflow); end
        checks++; if (bus8.DATAOUT !== 8'd0) begin errors++; $display("FAIL reset_dout got %0d exp 0", bus8.DATAOUT); end
    endtask

    task automatic test_fill_drain();
        logic [7:0] vals [7];
        vals = '{8'd100, 8'd150, 8'd200, 8'd40, 8'd70, 8'd65, 8'd15};
        for (int i = 0; i < 7; i++) cyc8(1'b1, 1'b0, vals[i]);
        checks++; if (bus8.count !== 4'd7) begin errors++; $display("FAIL fill_count got %0d exp 7", bus8.count); end
        checks++; if (bus8.almost_full !== 1'b1) begin errors++; $display("FAIL fill_af got %b exp 1", bus8.almost_full); end
        checks++; if (bus8.full !== 1'b0) begin errors++; $display("FAIL fill_full got %b exp 0", bus8.full); end
        for (int i = 0; i < 7; i++) begin
            cyc8(1'b0, 1'b1, 8'd0);
            checks++; if (bus8.DATAOUT !== vals[i]) begin errors++; $display("FAIL drain_dout[%0d] got %0d exp %0d", i, bus8.DATAOUT, vals[i]); end
            if (i == 5) begin
                checks++; if (bus8.almost_empty !== 1'b1) begin errors++; $display("FAIL drain_ae got %b exp 1", bus8.almost_empty); end
            end
        end
        checks++; if (bus8.empty !== 1'b1) begin errors++; $display("FAIL drain_empty got %b exp 1", bus8.empty); end
        checks++; if (bus8.count !== 4'd0) begin errors++; $display("FAIL drain_count got %0d exp 0", bus8.count); end
    endtask

    task automatic test_underflow();
        cyc8(1'b0, 1'b1, 8'd0);
        checks++; if (bus8.DATAOUT !== 8'd15) begin errors++; $display("FAIL udf_hold got %0d exp 15", bus8.DATAOUT); end
        checks++; if (bus8.underflow !== 1'b1) begin errors++; $display("FAIL udf_flag got %b exp 1", bus8.underflow); end
        checks++; if (bus8.empty !== 1'b1) begin errors++; $display("FAIL udf_empty got %b exp 1", bus8.empty); end
        checks++; if (bus8.count !== 4'd0) begin errors++; $display("FAIL udf_count got %0d exp 0", bus8.count); end
    endtask

    task automatic test_overflow();
        rst8();
        for (int i = 0; i < 8; i++) cyc8(1'b1, 1'b0, 8'h10 + 8'(i));
        checks++; if (bus8.full !== 1'b1) begin errors++; $display("FAIL ovf_full got %b exp 1", bus8.full); end
        checks++; if (bus8.overflow !== 1'b0) begin errors++; $display("FAIL ovf_pre got %b exp 0", bus8.overflow); end
        cyc8(1'b1, 1'b0, 8'hAA);
        checks++; if (bus8.overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag got %b exp 1", bus8.overflow); end
        checks++; if (bus8.count !== 4'd8) begin errors++; $display("FAIL ovf_count got %0d exp 8", bus8.count); end
        for (int i = 0; i < 8; i++) begin
            cyc8(1'b0, 1'b1, 8'd0);
            checks++; if (bus8.DATAOUT !== (8'h10 + 8'(i))) begin errors++; $display("FAIL ovf_drain[%0d] got %0h exp %0h", i, bus8.DATAOUT, 8'h10 + 8'(i)); end
        end
        checks++; if (bus8.empty !== 1'b1) begin errors++; $display("FAIL ovf_empty got %b exp 1", bus8.empty); end
        checks++; if (bus8.overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky got %b exp 1", bus8.overflow); end
        checks++; if (bus8.underflow !== 1'b0) begin errors++; $display("FAIL ovf_udf got %b exp 0", bus8.underflow); end
    endtask

    task automatic test_full_rw();
        rst8();
        for (int i = 1; i <= 8; i++) cyc8(1'b1, 1'b0, 8'(i));
        cyc8(1'b1, 1'b1, 8'd9);
        checks++; if (bus8.DATAOUT !== 8'd1) begin errors++; $display("FAIL frw_dout got %0d exp 1", bus8.DATAOUT); end
        checks++; if (bus8.count !== 4'd8) begin errors++; $display("FAIL frw_count got %0d exp 8", bus8.count); end
        checks++; if (bus8.overflow !== 1'b0) begin errors++; $display("FAIL frw_ovf got %b exp 0", bus8.overflow); end
        for (int i = 2; i <= 9; i++) begin
            cyc8(1'b0, 1'b1, 8'd0);
            checks++; if (bus8.DATAOUT !== 8'(i)) begin errors++; $display("FAIL frw_drain got %0d exp %0d", bus8.DATAOUT, i); end
        end
        checks++; if (bus8.empty !== 1'b1) begin errors++; $display("FAIL frw_empty got %b exp 1", bus8.empty); end
    endtask

    task automatic test_empty_rw();
        cyc8(1'b1, 1'b1, 8'h33);
        checks++; if (bus8.count !== 4'd1) begin errors++; $display("FAIL erw_count got %0d exp 1", bus8.count); end
        checks++; if (bus8.underflow !== 1'b1) begin errors++; $display("FAIL erw_udf got %b exp 1", bus8.underflow); end
        checks++; if (bus8.DATAOUT !== 8'd9) begin errors++; $display("FAIL erw_hold got %0d exp 9", bus8.DATAOUT); end
        cyc8(1'b0, 1'b1, 8'd0);
        checks++; if (bus8.DATAOUT !== 8'h33) begin errors++; $display("FAIL erw_read got %0h exp 33", bus8.DATAOUT); end
    endtask

    task automatic test_wrap5();
        reset5 = 1'b1;
        cyc5(1'b0, 1'b0, 8'd0);
        reset5 = 1'b0;
        for (int i = 1; i <= 4; i++) cyc5(1'b1, 1'b0, 8'(i));
        checks++; if (bus5.almost_full !== 1'b1) begin errors++; $display("FAIL w5_af got %b exp 1", bus5.almost_full); end
        for (int v = 5; v <= 12; v++) begin
            cyc5(1'b1, 1'b1, 8'(v));
            checks++; if (bus5.DATAOUT !== 8'(v - 4)) begin errors++; $display("FAIL w5_dout got %0d exp %0d", bus5.DATAOUT, v - 4); end
            checks++; if (bus5.count !== 3'd4) begin errors++; $display("FAIL w5_count got %0d exp 4", bus5.count); end
        end
        cyc5(1'b1, 1'b0, 8'd13);
        checks++; if (bus5.full !== 1'b1) begin errors++; $display("FAIL w5_full got %b exp 1", bus5.full); end
        checks++; if (bus5.count !== 3'd5) begin errors++; $display("FAIL w5_count5 got %0d exp 5", bus5.count); end
        for (int v = 9; v <= 13; v++) begin
            cyc5(1'b0, 1'b1, 8'd0);
            checks++; if (bus5.DATAOUT !== 8'(v)) begin errors++; $display("FAIL w5_drain got %0d exp %0d", bus5.DATAOUT, v); end
        end
        checks++; if (bus5.empty !== 1'b1) begin errors++; $display("FAIL w5_empty got %b exp 1", bus5.empty); end
        checks++; if (bus5.overflow !== 1'b0) begin errors++; $display("FAIL w5_ovf got %b exp 0", bus5.overflow); end
    endtask

    task automatic test_mid_reset();
        rst8();
        cyc8(1'b0, 1'b1, 8'd0);
        checks++; if (bus8.underflow !== 1'b1) begin errors++; $display("FAIL mr_udf_pre got %b exp 1", bus8.underflow); end
        cyc8(1'b1, 1'b0, 8'h11);
        cyc8(1'b1, 1'b0, 8'h22);
        cyc8(1'b1, 1'b0, 8'h33);
        cyc8(1'b0, 1'b1, 8'd0);
        checks++; if (bus8.DATAOUT !== 8'h11) begin errors++; $display("FAIL mr_pre_dout got %0h exp 11", bus8.DATAOUT); end
        rst8();
        checks++; if (bus8.count !== 4'd0) begin errors++; $display("FAIL mr_count got %0d exp 0", bus8.count); end
        checks++; if (bus8.empty !== 1'b1) begin errors++; $display("FAIL mr_empty got %b exp 1", bus8.empty); end
        checks++; if (bus8.overflow !== 1'b0) begin errors++; $display("FAIL mr_ovf got %b exp 0", bus8.overflow); end
        checks++; if (bus8.underflow !== 1'b0) begin errors++; $display("FAIL mr_udf got %b exp 0", bus8.underflow); end
        checks++; if (bus8.DATAOUT !== 8'd0) begin errors++; $display("FAIL mr_dout got %0h exp 0", bus8.DATAOUT); end
        cyc8(1'b1, 1'b0, 8'h5A);
        checks++; if (bus8.count !== 4'd1) begin errors++; $display("FAIL mr_wcount got %0d exp 1", bus8.count); end
        cyc8(1'b0, 1'b1, 8'd0);
        checks++; if (bus8.DATAOUT !== 8'h5A) begin errors++; $display("FAIL mr_read got %0h exp 5a", bus8.DATAOUT); end
        checks++; if (bus8.empty !== 1'b1) begin errors++; $display("FAIL mr_empty2 got %b exp 1", bus8.empty); end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset8 = 1'b1;
        reset5 = 1'b1;
        bus8.wn = 1'b0; bus8.rn = 1'b0; bus8.DATAIN = 8'd0;
        bus5.wn = 1'b0; bus5.rn = 1'b0; bus5.DATAIN = 8'd0;
        test_reset();
        test_fill_drain();
        test_underflow();
        test_overflow();
        test_full_rw();
        test_empty_rw();
        test_wrap5();
        test_mid_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fifo_param.md
Name: fifo_param

Overview:
- Parametrised synchronous single-clock FIFO; next generation of the team's fixed 8-bit FIFO.
- Adds configurable width and depth, an occupancy count, almost-full/almost-empty thresholds and sticky overflow/underflow error flags.
- Defined simultaneous read/write behaviour, including at the full and empty boundaries.
- Sits between a producer and a consumer in the same clock domain.

Parameters:
- WIDTH, 8: data word width in bits; must be at least 1.
- DEPTH, 8: number of storage entries; must be at least 2. Not required to be a power of two.
- AF_MARGIN, 1: almost_full asserts when count >= DEPTH - AF_MARGIN. Legal range 0 to DEPTH-1.
- AE_MARGIN, 1: almost_empty asserts when count <= AE_MARGIN. Legal range 0 to DEPTH-1.

Ports:
- clock  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- wn  in  1  write request.
- rn  in  1  read request.
- DATAIN  in  WIDTH  write data.
- DATAOUT  out  WIDTH  read data, registered.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.
- almost_full  out  1  threshold flag (see Parameters).
- almost_empty  out  1  threshold flag (see Parameters).
- count  out  CW  current occupancy, where CW = clog2(DEPTH+1).
- overflow  out  1  sticky: a write was dropped.
- underflow  out  1  sticky: a read was refused.

Behaviour:
- Reset: reset=1 at a rising edge sets the following on that edge.
  - Pointers = 0, count = 0, DATAOUT = 0.
  - empty = 1, full = 0, almost_empty = 1, overflow = 0, underflow = 0.
  - almost_full = 1 only if AF_MARGIN == DEPTH, otherwise 0.
  - Memory contents are not cleared. Reset has priority over wn and rn.
- Reset mid-operation: all queued data is discarded. The first write after reset lands at entry 0.
- Write acceptance: wr_ok = wn && (!full || rn). The word at the write pointer is DATAIN; the write pointer advances.
- Read acceptance: rd_ok = rn && !empty. On the same edge, DATAOUT loads the head entry and the read pointer advances.
  - Read latency: DATAOUT is valid immediately after the clock edge on which rn was sampled.
  - When no read is accepted, DATAOUT holds its previous value.
- Pointer wrap: each pointer is clog2(DEPTH) bits. It wraps from DEPTH-1 to 0 explicitly; it must not rely on natural binary overflow.
- Count update: +1 for a write only, -1 for a read only, unchanged for both or neither.
  - All flags are derived combinationally from the registered count.
- Simultaneous read and write when full: both are accepted, count stays at DEPTH, no overflow.
- Simultaneous read and write when empty: the write is accepted and the read is refused (no bypass).
  - count becomes 1, underflow sets, DATAOUT holds.
- Overflow: wn=1 with full=1 and rn=0 drops the data and sets overflow. FIFO state is unchanged.
- Underflow: rn=1 with empty=1 sets underflow.
- Error flags stay set until the next reset.
- Undefined inputs: X on wn or rn is a bench error. No special RTL handling is required.

Decomposition:
- Shared package fifo_pkg holds:
  - the clog2 function,
  - default WIDTH and DEPTH constants,
  - the pointer-increment-with-wrap function.
- Sub-module fifo_mem: a simple dual-port register array.
  - One synchronous write port (we, waddr, wdata).
  - One synchronous read port (re, raddr, rdata) with hold-when-not-read behaviour. The rdata register is DATAOUT.
- The top level holds the pointers, the count and the flags. The target is roughly 150–250 lines of RTL in total.

Test Plan:
1. Fill/drain in order (DEPTH=8, WIDTH=8): reset, then write 100, 150, 200, 40, 70, 65, 15.
   - count must read 7 and almost_full must be 1.
   - Then 7 reads must return DATAOUT 100, 150, 200, 40, 70, 65, 15 in order.
   - After the last read, empty=1 and count=0.
2. Overflow: write 8 words, full=1. A 9th write of 0xAA gives overflow=1 and count=8. Draining 8 reads never returns 0xAA.
3. Underflow and hold: after scenario 1, one more read leaves DATAOUT=15, sets underflow=1 and keeps empty=1.
4. Full read-and-write: with 8 words queued (1..8), assert wn=rn=1 with DATAIN=9.
   - DATAOUT=1, count stays 8, overflow=0.
   - A subsequent drain returns 2..9.
5. Wrap with non-power-of-two depth (DEPTH=5): run 12 interleaved write/read pairs of values 1..12. Output order is 1..12 and count never exceeds 5.
6. Mid-operation reset: with 3 words queued, pulse reset for one cycle.
   - count=0, empty=1, overflow=0, underflow=0, DATAOUT=0.
   - Write 0x5A then read: DATAOUT=0x5A.
